// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base and MM:SS.CC BCD accumulator with lap-freeze display
// and a sticky overflow flag for the display/segment driver stage.
`timescale 1ns/1ps
module stopwatch_time_counter #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_enable,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] disp_min_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_cs_tens,
  output logic [3:0] disp_cs_ones,
  output logic       lap_active,
  output logic       tick,
  output logic       overflow
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIGIT_W = 4;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DIGIT_W-1:0] D_ZERO   = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] D_FIVE   = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] D_NINE   = DIGIT_W'(9);

  if (((CLK_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_params
    $error("stopwatch_time_counter: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2");
  end

  logic [PRE_W-1:0]   r_prescaler;
  logic [DIGIT_W-1:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones, r_cs_tens, r_cs_ones;
  logic [DIGIT_W-1:0] r_lap_min_tens, r_lap_min_ones, r_lap_sec_tens;
  logic [DIGIT_W-1:0] r_lap_sec_ones, r_lap_cs_tens, r_lap_cs_ones;
  logic               r_lap_active;
  logic               r_tick;
  logic               r_overflow;

  logic [PRE_W-1:0]   w_prescaler_nxt;
  logic [DIGIT_W-1:0] w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt;
  logic [DIGIT_W-1:0] w_sec_ones_nxt, w_cs_tens_nxt, w_cs_ones_nxt;
  logic [DIGIT_W-1:0] w_lap_min_tens_nxt, w_lap_min_ones_nxt, w_lap_sec_tens_nxt;
  logic [DIGIT_W-1:0] w_lap_sec_ones_nxt, w_lap_cs_tens_nxt, w_lap_cs_ones_nxt;
  logic               w_lap_active_nxt;
  logic               w_tick_nxt;
  logic               w_overflow_nxt;

  logic               w_period_end;
  logic               w_c_cs_ones, w_c_cs_tens, w_c_sec_ones;
  logic               w_c_sec_tens, w_c_min_ones, w_c_min_tens;
  logic [DIGIT_W-1:0] w_inc_min_tens, w_inc_min_ones, w_inc_sec_tens;
  logic [DIGIT_W-1:0] w_inc_sec_ones, w_inc_cs_tens, w_inc_cs_ones;

  // Ripple carry: each digit rolls when it and every lower digit sit at their
  // maximum; >= comparisons pull any out-of-range value back into range.
  always_comb begin
    w_period_end = (r_prescaler >= PRE_LAST);
    w_c_cs_ones  = (r_cs_ones  >= D_NINE);
    w_c_cs_tens  = w_c_cs_ones  && (r_cs_tens  >= D_NINE);
    w_c_sec_ones = w_c_cs_tens  && (r_sec_ones >= D_NINE);
    w_c_sec_tens = w_c_sec_ones && (r_sec_tens >= D_FIVE);
    w_c_min_ones = w_c_sec_tens && (r_min_ones >= D_NINE);
    w_c_min_tens = w_c_min_ones && (r_min_tens >= D_FIVE);

    w_inc_cs_ones  = w_c_cs_ones  ? D_ZERO : r_cs_ones + DIGIT_W'(1);
    w_inc_cs_tens  = r_cs_tens;
    w_inc_sec_ones = r_sec_ones;
    w_inc_sec_tens = r_sec_tens;
    w_inc_min_ones = r_min_ones;
    w_inc_min_tens = r_min_tens;
    if (w_c_cs_ones)  w_inc_cs_tens  = w_c_cs_tens  ? D_ZERO : r_cs_tens  + DIGIT_W'(1);
    if (w_c_cs_tens)  w_inc_sec_ones = w_c_sec_ones ? D_ZERO : r_sec_ones + DIGIT_W'(1);
    if (w_c_sec_ones) w_inc_sec_tens = w_c_sec_tens ? D_ZERO : r_sec_tens + DIGIT_W'(1);
    if (w_c_sec_tens) w_inc_min_ones = w_c_min_ones ? D_ZERO : r_min_ones + DIGIT_W'(1);
    if (w_c_min_ones) w_inc_min_tens = w_c_min_tens ? D_ZERO : r_min_tens + DIGIT_W'(1);
  end

  // Next-state: clear dominates; otherwise prescale/advance and lap toggle.
  always_comb begin
    w_prescaler_nxt    = r_prescaler;
    w_min_tens_nxt     = r_min_tens;
    w_min_ones_nxt     = r_min_ones;
    w_sec_tens_nxt     = r_sec_tens;
    w_sec_ones_nxt     = r_sec_ones;
    w_cs_tens_nxt      = r_cs_tens;
    w_cs_ones_nxt      = r_cs_ones;
    w_lap_min_tens_nxt = r_lap_min_tens;
    w_lap_min_ones_nxt = r_lap_min_ones;
    w_lap_sec_tens_nxt = r_lap_sec_tens;
    w_lap_sec_ones_nxt = r_lap_sec_ones;
    w_lap_cs_tens_nxt  = r_lap_cs_tens;
    w_lap_cs_ones_nxt  = r_lap_cs_ones;
    w_lap_active_nxt   = r_lap_active;
    w_tick_nxt         = 1'b0;
    w_overflow_nxt     = r_overflow;

    if (clear) begin
      w_prescaler_nxt    = '0;
      w_min_tens_nxt     = D_ZERO;
      w_min_ones_nxt     = D_ZERO;
      w_sec_tens_nxt     = D_ZERO;
      w_sec_ones_nxt     = D_ZERO;
      w_cs_tens_nxt      = D_ZERO;
      w_cs_ones_nxt      = D_ZERO;
      w_lap_min_tens_nxt = D_ZERO;
      w_lap_min_ones_nxt = D_ZERO;
      w_lap_sec_tens_nxt = D_ZERO;
      w_lap_sec_ones_nxt = D_ZERO;
      w_lap_cs_tens_nxt  = D_ZERO;
      w_lap_cs_ones_nxt  = D_ZERO;
      w_lap_active_nxt   = 1'b0;
      w_overflow_nxt     = 1'b0;
    end else begin
      if (count_enable) begin
        if (w_period_end) begin
          w_prescaler_nxt = '0;
          w_tick_nxt      = 1'b1;
          w_min_tens_nxt  = w_inc_min_tens;
          w_min_ones_nxt  = w_inc_min_ones;
          w_sec_tens_nxt  = w_inc_sec_tens;
          w_sec_ones_nxt  = w_inc_sec_ones;
          w_cs_tens_nxt   = w_inc_cs_tens;
          w_cs_ones_nxt   = w_inc_cs_ones;
          if (w_c_min_tens) w_overflow_nxt = 1'b1;
        end else begin
          w_prescaler_nxt = r_prescaler + PRE_W'(1);
        end
      end
      // Lap captures the live value as it stands before this edge.
      if (lap) begin
        w_lap_active_nxt = !r_lap_active;
        if (!r_lap_active) begin
          w_lap_min_tens_nxt = r_min_tens;
          w_lap_min_ones_nxt = r_min_ones;
          w_lap_sec_tens_nxt = r_sec_tens;
          w_lap_sec_ones_nxt = r_sec_ones;
          w_lap_cs_tens_nxt  = r_cs_tens;
          w_lap_cs_ones_nxt  = r_cs_ones;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler    <= '0;
      r_min_tens     <= D_ZERO;
      r_min_ones     <= D_ZERO;
      r_sec_tens     <= D_ZERO;
      r_sec_ones     <= D_ZERO;
      r_cs_tens      <= D_ZERO;
      r_cs_ones      <= D_ZERO;
      r_lap_min_tens <= D_ZERO;
      r_lap_min_ones <= D_ZERO;
      r_lap_sec_tens <= D_ZERO;
      r_lap_sec_ones <= D_ZERO;
      r_lap_cs_tens  <= D_ZERO;
      r_lap_cs_ones  <= D_ZERO;
      r_lap_active   <= 1'b0;
      r_tick         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_prescaler    <= w_prescaler_nxt;
      r_min_tens     <= w_min_tens_nxt;
      r_min_ones     <= w_min_ones_nxt;
      r_sec_tens     <= w_sec_tens_nxt;
      r_sec_ones     <= w_sec_ones_nxt;
      r_cs_tens      <= w_cs_tens_nxt;
      r_cs_ones      <= w_cs_ones_nxt;
      r_lap_min_tens <= w_lap_min_tens_nxt;
      r_lap_min_ones <= w_lap_min_ones_nxt;
      r_lap_sec_tens <= w_lap_sec_tens_nxt;
      r_lap_sec_ones <= w_lap_sec_ones_nxt;
      r_lap_cs_tens  <= w_lap_cs_tens_nxt;
      r_lap_cs_ones  <= w_lap_cs_ones_nxt;
      r_lap_active   <= w_lap_active_nxt;
      r_tick         <= w_tick_nxt;
      r_overflow     <= w_overflow_nxt;
    end
  end

  // Display is a zero-latency mux between frozen lap and live registers.
  always_comb begin
    if (r_lap_active) begin
      disp_min_tens = r_lap_min_tens;
      disp_min_ones = r_lap_min_ones;
      disp_sec_tens = r_lap_sec_tens;
      disp_sec_ones = r_lap_sec_ones;
      disp_cs_tens  = r_lap_cs_tens;
      disp_cs_ones  = r_lap_cs_ones;
    end else begin
      disp_min_tens = r_min_tens;
      disp_min_ones = r_min_ones;
      disp_sec_tens = r_sec_tens;
      disp_sec_ones = r_sec_ones;
      disp_cs_tens  = r_cs_tens;
      disp_cs_ones  = r_cs_ones;
    end
  end

  assign lap_active = r_lap_active;
  assign tick       = r_tick;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: elapsed-centisecond model plus directed
// scenarios (timebase, pause, carry, wrap, lap, clear priority, async reset).
`timescale 1ns/1ps
module tb_stopwatch_time_counter;

  localparam int DIV    = 4;
  localparam int T_MAX  = 359999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic count_enable = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic [3:0] disp_min_tens, disp_min_ones, disp_sec_tens;
  logic [3:0] disp_sec_ones, disp_cs_tens, disp_cs_ones;
  logic lap_active, tick, overflow;
  logic [23:0] disp_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: elapsed time as plain centiseconds
  int m_t = 0, m_pre = 0, m_lap = 0;
  bit m_lap_act = 1'b0, m_tick = 1'b0, m_ovf = 1'b0;
  bit chk_en = 1'b0;
  bit preload_req = 1'b0;
  int preload_val = 0;

  stopwatch_time_counter #(.CLK_HZ(4), .TICK_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .count_enable(count_enable), .clear(clear), .lap(lap),
    .disp_min_tens(disp_min_tens), .disp_min_ones(disp_min_ones),
    .disp_sec_tens(disp_sec_tens), .disp_sec_ones(disp_sec_ones),
    .disp_cs_tens(disp_cs_tens), .disp_cs_ones(disp_cs_ones),
    .lap_active(lap_active), .tick(tick), .overflow(overflow)
  );

  assign disp_w = {disp_min_tens, disp_min_ones, disp_sec_tens,
                   disp_sec_ones, disp_cs_tens, disp_cs_ones};

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int mm, ss, cs;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cs = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference behaviour in terms of elapsed centiseconds
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_pre <= 0; m_lap <= 0;
      m_lap_act <= 1'b0; m_tick <= 1'b0; m_ovf <= 1'b0;
    end else if (preload_req) begin
      m_t <= preload_val;
      m_tick <= 1'b0;
    end else if (clear) begin
      m_t <= 0; m_pre <= 0; m_lap <= 0;
      m_lap_act <= 1'b0; m_tick <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      if (count_enable) begin
        if (m_pre == DIV - 1) begin
          m_pre  <= 0;
          m_tick <= 1'b1;
          if (m_t == T_MAX) begin
            m_t   <= 0;
            m_ovf <= 1'b1;
          end else begin
            m_t <= m_t + 1;
          end
        end else begin
          m_pre <= m_pre + 1;
        end
      end
      if (lap) begin
        if (!m_lap_act) m_lap <= m_t;
        m_lap_act <= !m_lap_act;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model", {5'b0, lap_active, overflow, tick, disp_w},
            {5'b0, m_lap_act, m_ovf, m_tick, to_bcd(m_lap_act ? m_lap : m_t)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  // Loads the live digits directly so the wrap region is reachable quickly.
  task automatic preload(input int t);
    logic [23:0] b;
    b = to_bcd(t);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    dut.r_min_tens <= b[23:20];
    dut.r_min_ones <= b[19:16];
    dut.r_sec_tens <= b[15:12];
    dut.r_sec_ones <= b[11:8];
    dut.r_cs_tens  <= b[7:4];
    dut.r_cs_ones  <= b[3:0];
    preload_val = t;
    preload_req = 1'b1;
    @(posedge clk);
    #1;
    preload_req = 1'b0;
    chk_en = 1'b1;
    cyc(1);
  endtask

  initial begin
    cyc(2);
    check("reset_disp", {8'b0, disp_w}, 32'h0);
    check("reset_flags", {29'b0, lap_active, overflow, tick}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Timebase: ticks on enabled cycles 4 and 8 only
    count_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check($sformatf("timebase_tick_%0d", i + 1), {31'b0, tick}, {31'b0, (i == 3 || i == 7)});
    end
    count_enable = 1'b0;
    check("timebase_disp", {8'b0, disp_w}, 32'h000002);

    // Pause keeps the partial period
    pulse_clear();
    count_enable = 1'b1;
    cyc(3);
    count_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("pause_no_tick", {31'b0, tick}, 32'h0);
    end
    count_enable = 1'b1;
    cyc(1);
    count_enable = 1'b0;
    check("pause_resume_tick", {31'b0, tick}, 32'h1);
    check("pause_disp", {8'b0, disp_w}, 32'h000001);

    // Lap capture coinciding with a tick takes the pre-increment value
    pulse_clear();
    count_enable = 1'b1;
    cyc(3);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check("lap_coincide_disp", {8'b0, disp_w}, 32'h000000);
    check("lap_coincide_flags", {29'b0, lap_active, overflow, tick}, 32'h5);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    count_enable = 1'b0;
    check("lap_coincide_release", {8'b0, disp_w}, 32'h000001);

    // Lap freeze while live time advances
    pulse_clear();
    count_enable = 1'b1;
    cyc(37 * DIV);
    check("lap_pre", {8'b0, disp_w}, 32'h000037);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check("lap_frozen", {7'b0, lap_active, disp_w}, {7'b0, 1'b1, 24'h000037});
    cyc(20 * DIV - 1);
    check("lap_held", {7'b0, lap_active, disp_w}, {7'b0, 1'b1, 24'h000037});
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check("lap_released", {7'b0, lap_active, disp_w}, {7'b0, 1'b0, 24'h000057});
    count_enable = 1'b0;

    // Carry chain up to one minute
    pulse_clear();
    count_enable = 1'b1;
    cyc(5999 * DIV);
    check("carry_5999", {8'b0, disp_w}, 32'h005999);
    cyc(DIV);
    check("carry_1min", {8'b0, disp_w}, 32'h010000);
    count_enable = 1'b0;

    // Full wrap sets sticky overflow
    pulse_clear();
    preload(T_MAX - 1);
    count_enable = 1'b1;
    cyc(DIV);
    check("wrap_max", {7'b0, overflow, disp_w}, {7'b0, 1'b0, 24'h595999});
    cyc(DIV);
    check("wrap_zero", {6'b0, overflow, tick, disp_w}, {6'b0, 2'b11, 24'h000000});
    cyc(2 * DIV);
    check("wrap_sticky", {7'b0, overflow, disp_w}, {7'b0, 1'b1, 24'h000002});
    count_enable = 1'b0;

    // Clear beats a coincident tick and lap
    pulse_clear();
    preload(T_MAX);
    count_enable = 1'b1;
    cyc(DIV);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    cyc(DIV - 2);
    check("clr_setup", {29'b0, lap_active, overflow, tick}, 32'h6);
    clear = 1'b1;
    lap = 1'b1;
    cyc(1);
    clear = 1'b0;
    lap = 1'b0;
    check("clr_disp", {8'b0, disp_w}, 32'h0);
    check("clr_flags", {29'b0, lap_active, overflow, tick}, 32'h0);
    for (int i = 0; i < DIV; i++) begin
      cyc(1);
      check($sformatf("clr_next_tick_%0d", i + 1), {31'b0, tick}, {31'b0, (i == DIV - 1)});
    end
    check("clr_next_disp", {8'b0, disp_w}, 32'h000001);

    // Asynchronous reset mid-run
    pulse_clear();
    count_enable = 1'b1;
    cyc(1234 * DIV);
    check("areset_pre", {8'b0, disp_w}, 32'h001234);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_disp", {8'b0, disp_w}, 32'h0);
    check("areset_flags", {29'b0, lap_active, overflow, tick}, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < DIV; i++) begin
      cyc(1);
      check($sformatf("areset_tick_%0d", i + 1), {31'b0, tick}, {31'b0, (i == DIV - 1)});
    end
    check("areset_after", {8'b0, disp_w}, 32'h000001);
    count_enable = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Downstream consumer of the stopwatch control FSM's count_enable. It divides clk down to a 10 ms timebase and accumulates elapsed time in a BCD chain (MM:SS.CC, max 59:59.99). It provides a lap-freeze display path and a sticky overflow flag to the display/segment driver stage.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 100, timebase frequency in Hz (1 tick = 1 centisecond at default); DIV = CLK_HZ/TICK_HZ

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
count_enable  input  1  from control FSM; high = RUNNING, prescaler and time advance
clear  input  1  synchronous clear pulse (driven from same reset request as FSM)
lap  input  1  single-cycle pulse; toggles lap freeze
disp_min_tens  output  4  displayed minutes tens, BCD 0-5
disp_min_ones  output  4  displayed minutes ones, BCD 0-9
disp_sec_tens  output  4  displayed seconds tens, BCD 0-5
disp_sec_ones  output  4  displayed seconds ones, BCD 0-9
disp_cs_tens  output  4  displayed centiseconds tens, BCD 0-9
disp_cs_ones  output  4  displayed centiseconds ones, BCD 0-9
lap_active  output  1  1 = display shows frozen lap value
tick  output  1  registered 1-cycle pulse, high the cycle the live time changes
overflow  output  1  sticky; set on wrap from 59:59.99

Behaviour:
- Reset (rst_n low, async): prescaler=0, all live and lap digits=0, lap_active=0, tick=0, overflow=0. All outputs read 00:00.00.
- DIV = CLK_HZ/TICK_HZ. Requirements: CLK_HZ an exact multiple of TICK_HZ, DIV >= 2. Prescaler width = clog2(DIV).
- Prescaler: counts 0..DIV-1 only while count_enable=1. count_enable=0 holds it (pause keeps partial period; no loss or gain on resume).
- On an edge with count_enable=1 and prescaler=DIV-1: prescaler<=0, live time increments by one centisecond, tick<=1. Otherwise tick<=0.
- The new digit value and tick are visible in the same cycle, DIV enabled cycles after the last tick or clear.
- BCD chain, ripple carry in one cycle: cs_ones 9->0 carries to cs_tens; cs_tens 9->0 to sec_ones; sec_ones 9->0 to sec_tens; sec_tens 5->0 to min_ones; min_ones 9->0 to min_tens; min_tens 5->0 is a full wrap.
- Wrap: 59:59.99 + tick -> 00:00.00, overflow<=1 on the same edge. overflow stays set until clear or reset. Counting continues after wrap.
- No digit ever holds a non-BCD or out-of-range value.
- clear=1: prescaler, live digits, lap digits, lap_active, overflow <= 0 and tick <= 0 on that edge.
  - clear has priority over a simultaneous tick and over a simultaneous lap.
  - clear is effective regardless of count_enable.
- lap pulse with lap_active=0: lap register <= live value as it stands before this edge (pre-increment if a tick coincides); lap_active<=1.
- lap pulse with lap_active=1: lap_active<=0; display returns to live value.
- lap is honoured while paused. Live time keeps running while lap_active=1.
- disp_* = lap register when lap_active=1, else live digits. This is a combinational mux of registers with no added latency.
- lap held high for several cycles toggles every cycle; the upstream FSM/debouncer guarantees single-cycle pulses.

Test Plan:
- Timebase: CLK_HZ=4, TICK_HZ=1 (DIV=4); reset, count_enable=1 for 8 cycles -> tick high on cycles 4 and 8 only; display 00:00.02.
- Pause accuracy (DIV=4): enable 3 cycles, disable 10, enable 1 -> one tick, on the first re-enabled edge; display 00:00.01; no tick during pause.
- Carry chain (DIV=2): run to 00:59.99, one more tick -> 01:00.00. Continue to 59:59.99, one more tick -> 00:00.00 with overflow=1. Overflow stays 1 through further ticks.
- Lap (DIV=2): run to 00:00.37, pulse lap -> disp 00:00.37, lap_active=1, held while live advances 20 ticks. Pulse lap -> disp 00:00.57, lap_active=0.
- Clear priority: assert clear on the edge where a tick and a lap coincide, with overflow=1 and lap_active=1 -> all digits 0, tick=0, lap_active=0, overflow=0. Next tick arrives exactly DIV enabled cycles later.
- Async reset mid-run: drop rst_n between clock edges at 00:12.34 -> outputs read 00:00.00 immediately without a clock edge. After release, counting restarts with prescaler at 0.
